// File: rtl/i2s_audio_tx_pkg.sv
// Shared audio-path definitions: default clock ratios and parameter sanity helpers.
package i2s_audio_tx_pkg;

  localparam int DEF_SCLK_DIV = 8;
  localparam int DEF_SLOT_W   = 32;
  localparam int DEF_SAMPLE_W = 16;

  function automatic int frame_clocks(input int sclk_div, input int slot_w);
    return 2 * slot_w * sclk_div;
  endfunction

  function automatic bit params_ok(input int sclk_div, input int slot_w, input int sample_w);
    return (sclk_div >= 2) && ((sclk_div % 2) == 0) &&
           (sample_w >= 1) && (sample_w <= slot_w);
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// I2S bit/word clock generator: divides the audio clock into SCLK and LRCLK
// and flags the SCLK falling edge and the serialiser load point.
module i2s_clkgen #(
  parameter int SCLK_DIV = 8,
  parameter int SLOT_W   = 32
) (
  input  logic clk_audio,
  input  logic rst_n,
  output logic sclk,
  output logic lrclk,
  output logic fall_tick,
  output logic load_tick
);

  localparam int DW = $clog2(SCLK_DIV);
  localparam int BW = $clog2(2 * SLOT_W);

  logic [DW-1:0] div_cnt, div_nxt;
  logic [BW-1:0] bit_cnt, bit_nxt;

  always_comb begin
    fall_tick = (div_cnt == DW'(SCLK_DIV - 1));
    div_nxt   = fall_tick ? '0 : div_cnt + DW'(1);
    bit_nxt   = (bit_cnt == BW'(2 * SLOT_W - 1)) ? '0 : bit_cnt + BW'(1);
    // bit 1 carries the left MSB, so the shift register is filled while entering it
    load_tick = fall_tick && (bit_nxt == BW'(1));
  end

  always_ff @(posedge clk_audio or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bit_cnt <= BW'(2 * SLOT_W - 1);
      sclk    <= 1'b0;
      lrclk   <= 1'b1;
    end else begin
      div_cnt <= div_nxt;
      sclk    <= (div_nxt >= DW'(SCLK_DIV / 2));
      if (fall_tick) begin
        bit_cnt <= bit_nxt;
        lrclk   <= (bit_nxt >= BW'(SLOT_W));
      end
    end
  end

endmodule

// File: rtl/i2s_audio_tx.sv
// Philips I2S transmitter: one-entry sample buffer behind a valid/ready port,
// serialised MSB-first with the standard one-bit delay after LRCLK.
module i2s_audio_tx
  import i2s_audio_tx_pkg::*;
#(
  parameter int SCLK_DIV = DEF_SCLK_DIV,
  parameter int SLOT_W   = DEF_SLOT_W,
  parameter int SAMPLE_W = DEF_SAMPLE_W
) (
  input  logic                clk_audio,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] in_left,
  input  logic [SAMPLE_W-1:0] in_right,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                i2s_sclk,
  output logic                i2s_lrclk,
  output logic                i2s_sdata,
  output logic                underrun
);

  localparam int FW = 2 * SLOT_W;

  if (!params_ok(SCLK_DIV, SLOT_W, SAMPLE_W) || frame_clocks(SCLK_DIV, SLOT_W) < 4) begin : g_param_check
    $error("i2s_audio_tx: SCLK_DIV must be even and >= 2, and SAMPLE_W must not exceed SLOT_W");
  end

  logic                fall_tick, load_tick, accept, buf_full;
  logic [SAMPLE_W-1:0] left_buf, right_buf;
  logic [FW-1:0]       shreg, shreg_nxt, frame_word;

  i2s_clkgen #(
    .SCLK_DIV (SCLK_DIV),
    .SLOT_W   (SLOT_W)
  ) u_clkgen (
    .clk_audio (clk_audio),
    .rst_n     (rst_n),
    .sclk      (i2s_sclk),
    .lrclk     (i2s_lrclk),
    .fall_tick (fall_tick),
    .load_tick (load_tick)
  );

  assign in_ready = !buf_full;
  assign accept   = in_valid && !buf_full;

  // Samples are left-justified in their slots; shifts avoid zero-width padding when SAMPLE_W == SLOT_W.
  assign frame_word = (FW'(left_buf)  << (FW - SAMPLE_W)) |
                      (FW'(right_buf) << (SLOT_W - SAMPLE_W));

  always_comb begin
    shreg_nxt = shreg;
    if (load_tick)
      shreg_nxt = buf_full ? frame_word : '0;
    else if (fall_tick)
      shreg_nxt = {shreg[FW-2:0], 1'b0};
  end

  always_ff @(posedge clk_audio or negedge rst_n) begin
    if (!rst_n) begin
      left_buf  <= '0;
      right_buf <= '0;
      buf_full  <= 1'b0;
      shreg     <= '0;
      i2s_sdata <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      // An accept on an empty-buffer load tick is held for the following frame.
      if (accept) begin
        left_buf  <= in_left;
        right_buf <= in_right;
        buf_full  <= 1'b1;
      end else if (load_tick) begin
        buf_full  <= 1'b0;
      end
      shreg    <= shreg_nxt;
      underrun <= load_tick && !buf_full;
      if (fall_tick)
        i2s_sdata <= shreg_nxt[FW-1];
    end
  end

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Directed bench for i2s_audio_tx: default 48 kHz instance plus a 24-bit, SCLK_DIV=2 instance.
module tb_i2s_audio_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rst2_n;
  logic [15:0] in_left, in_right;
  logic        in_valid, in_ready, sclk1, lr1, sd1, ur1;
  logic [23:0] l2, r2;
  logic        v2, rdy2, sclk2, lr2, sd2, ur2;

  int c, c2;
  int n_checks, n_fail;
  int n_acc, last_acc, prev_acc;
  bit prod_stop;
  logic sd1_prev, sd2_prev;

  i2s_audio_tx u_dut (
    .clk_audio (clk),
    .rst_n     (rst_n),
    .in_left   (in_left),
    .in_right  (in_right),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .i2s_sclk  (sclk1),
    .i2s_lrclk (lr1),
    .i2s_sdata (sd1),
    .underrun  (ur1)
  );

  i2s_audio_tx #(.SCLK_DIV(2), .SLOT_W(24), .SAMPLE_W(24)) u_dut24 (
    .clk_audio (clk),
    .rst_n     (rst2_n),
    .in_left   (l2),
    .in_right  (r2),
    .in_valid  (v2),
    .in_ready  (rdy2),
    .i2s_sclk  (sclk2),
    .i2s_lrclk (lr2),
    .i2s_sdata (sd2),
    .underrun  (ur2)
  );

  // Clocks since reset release; posedge k leaves c == k.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) c <= 0; else c <= c + 1;
  always @(posedge clk or negedge rst2_n)
    if (!rst2_n) c2 <= 0; else c2 <= c2 + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_lr(input int k, input int div, input int slot);
    if (k < div) return 1'b1;
    return (((k / div) - 1) % (2 * slot)) >= slot;
  endfunction

  function automatic bit is_load(input int k, input int div, input int slot);
    return (k % div == 0) && (k >= div) && ((((k / div) - 1) % (2 * slot)) == 1);
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      chk("sclk", sclk1, ((c % 8) >= 4));
      chk("lrclk", lr1, exp_lr(c, 8, 32));
      chk("sdata_off_tick", (sd1 != sd1_prev) && (c % 8 != 0), 0);
      chk("underrun_pos", ur1 && !is_load(c, 8, 32), 0);
      sd1_prev = sd1;
    end else sd1_prev = 1'b0;
    if (rst2_n) begin
      chk("sclk24", sclk2, ((c2 % 2) >= 1));
      chk("lrclk24", lr2, exp_lr(c2, 2, 24));
      chk("sdata24_off_tick", (sd2 != sd2_prev) && (c2 % 2 != 0), 0);
      chk("underrun24_pos", ur2 && !is_load(c2, 2, 24), 0);
      sd2_prev = sd2;
    end else sd2_prev = 1'b0;
  end

  function automatic int cnt_of(input int which);
    return (which == 2) ? c2 : c;
  endfunction

  task automatic wait_cnt(input int which, input int target);
    while (cnt_of(which) < target) @(negedge clk);
    if (cnt_of(which) != target) chk("sync", cnt_of(which), target);
  endtask

  // Bit b of frame f lands in fr[nb-1-b]; underrun is sampled at the load bit.
  task automatic get_frame(input int which, input int f, output logic [63:0] fr, output logic ur);
    int div = (which == 2) ? 2 : 8;
    int nb  = (which == 2) ? 48 : 64;
    fr = '0;
    ur = 1'b0;
    for (int b = 0; b < nb; b++) begin
      wait_cnt(which, div * (nb * f + b + 1));
      fr[nb-1-b] = (which == 2) ? sd2 : sd1;
      if (b == 1) ur = (which == 2) ? ur2 : ur1;
    end
  endtask

  task automatic producer();
    in_left  = 16'h1000;
    in_right = ~16'h1000;
    in_valid = 1'b1;
    while (!prod_stop) begin
      if (in_ready) begin
        n_acc++;
        prev_acc = last_acc;
        last_acc = c + 1;
        @(negedge clk);
        in_left  = in_left + 16'd1;
        in_right = ~in_left;
      end else @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] fr;
    logic        ur;
    logic [15:0] ev;
    n_checks = 0; n_fail = 0; n_acc = 0; last_acc = 0; prev_acc = 0;
    prod_stop = 1'b0;
    in_valid = 1'b0; in_left = '0; in_right = '0;
    v2 = 1'b0; l2 = '0; r2 = '0;
    rst_n = 1'b1; rst2_n = 1'b1;
    #1 rst_n = 1'b0; rst2_n = 1'b0;
    #1;
    chk("rst_sclk", sclk1, 0);
    chk("rst_lrclk", lr1, 1);
    chk("rst_sdata", sd1, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_underrun", ur1, 0);
    chk("rst24_lrclk", lr2, 1);
    chk("rst24_ready", rdy2, 1);
    @(negedge clk);
    #2 rst_n = 1'b1;

    for (int f = 0; f < 2; f++) begin
      get_frame(1, f, fr, ur);
      chk("idle_data", fr, 64'h0);
      chk("idle_underrun", ur, 1);
    end

    wait_cnt(1, 8 * (64 * 2 + 10));
    in_left = 16'hA5C3; in_right = 16'h8001; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_left = 16'hFFFF; in_right = 16'hFFFF;
    chk("ready_after_accept", in_ready, 0);
    get_frame(1, 3, fr, ur);
    chk("frame_a5c3_8001", fr, {1'b0, 16'hA5C3, 16'h0000, 16'h8001, 15'h0000});
    chk("frame_a5c3_underrun", ur, 0);
    chk("ready_after_load", in_ready, 1);
    get_frame(1, 4, fr, ur);
    chk("no_repeat_data", fr, 64'h0);
    chk("no_repeat_underrun", ur, 1);

    fork producer(); join_none
    for (int f = 5; f < 9; f++) begin
      ev = 16'h1000 + 16'(f - 5);
      get_frame(1, f, fr, ur);
      chk("stream_data", fr, {1'b0, ev, 16'h0000, ~ev, 15'h0000});
      chk("stream_underrun", ur, 0);
    end
    chk("stream_accepts", n_acc, 5);
    chk("stream_accept_spacing", last_acc - prev_acc, 512);
    wait_cnt(1, 8 * (64 * 9 + 10));
    prod_stop = 1'b1;
    wait_cnt(1, 8 * (64 * 9 + 12));
    chk("ready_full_before_reset", in_ready, 0);
    chk("lrclk_before_reset", lr1, 0);

    #2 rst_n = 1'b0;
    #1;
    chk("midrst_sclk", sclk1, 0);
    chk("midrst_lrclk", lr1, 1);
    chk("midrst_sdata", sd1, 0);
    chk("midrst_ready", in_ready, 1);
    chk("midrst_underrun", ur1, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    get_frame(1, 0, fr, ur);
    chk("post_rst_data", fr, 64'h0);
    chk("post_rst_underrun", ur, 1);

    fork
      get_frame(1, 1, fr, ur);
      begin
        wait_cnt(1, 527);
        in_left = 16'h1234; in_right = 16'h0F0F; in_valid = 1'b1;
        wait_cnt(1, 528);
        in_valid = 1'b0;
        chk("ready_after_tick_accept", in_ready, 0);
      end
    join
    chk("tick_accept_frame_data", fr, 64'h0);
    chk("tick_accept_frame_underrun", ur, 1);
    get_frame(1, 2, fr, ur);
    chk("tick_accept_next_data", fr, {1'b0, 16'h1234, 16'h0000, 16'h0F0F, 15'h0000});
    chk("tick_accept_next_underrun", ur, 0);

    @(negedge clk);
    #2 rst2_n = 1'b1;
    fork
      get_frame(2, 0, fr, ur);
      begin
        wait_cnt(2, 10);
        l2 = 24'h800000; r2 = 24'h000003; v2 = 1'b1;
        @(negedge clk);
        v2 = 1'b0;
        chk("w24_ready_after_accept", rdy2, 0);
      end
    join
    chk("w24_idle_data", fr, 64'h0);
    chk("w24_idle_underrun", ur, 1);
    get_frame(2, 1, fr, ur);
    chk("w24_frame_data", fr, {16'h0000, 1'b0, 24'h800000, 23'h000001});
    chk("w24_frame_underrun", ur, 0);
    get_frame(2, 2, fr, ur);
    chk("w24_right_lsb_wrap", fr, 64'h0000_8000_0000_0000);
    chk("w24_next_underrun", ur, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
